// File: rtl/prach_hb1_dmux.sv
// prach_hb1_dmux
//   Polyphase commutator ahead of the first PRACH half-band decimator.
//   It takes a TDM stream of up to NUM_CHANNEL interleaved channels. For
//   each channel it pairs consecutive samples into an (even, odd) pair and
//   emits both at once on dout_dp1/dout_dp2, together with the channel tag.
//
//   There are two register stages: pair capture, then the output register.
//   An odd sample presented in cycle n appears on the outputs in cycle n+2.
//   sync_out follows the same 2-cycle delay.
//
// Ports
//   clk, rst_n          clock; synchronous active-low reset
//   din_dq/dv/chn       input sample, valid and channel tag
//   sync_in             frame sync; clears every channel back to even phase
//   dout_dp1/dp2        even (older) and odd (newer) sample of the pair
//   dout_dv/chn         pair valid (one cycle per pair) and its channel tag
//   sync_out            sync_in delayed 2 cycles
//   err                 sticky channel-sequence error
//
// Build option
//   PRACH_HB1_DMUX_CHK_EN  enables the channel-sequence checker that drives
//                          err. When this macro is undefined, err is tied to 0.

module prach_hb1_dmux #(
    parameter int NUM_CHANNEL = 16,
    parameter int WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_dq,
    input  logic             din_dv,
    input  logic [7:0]       din_chn,
    input  logic             sync_in,
    output logic [WIDTH-1:0] dout_dp1,
    output logic [WIDTH-1:0] dout_dp2,
    output logic             dout_dv,
    output logic [7:0]       dout_chn,
    output logic             sync_out,
    output logic             err
);

    localparam int CW = $clog2(NUM_CHANNEL);

    logic [CW-1:0]          c;
    logic                   chn_ok;
    logic                   acc;
    logic                   odd;
    logic                   even_wr;

    logic [NUM_CHANNEL-1:0] ph;
    logic [WIDTH-1:0]       hold [NUM_CHANNEL];

    logic [1:0]             vld_pipe;   // [0] pair captured, [1] pair on outputs
    logic [1:0]             sync_pipe;
    logic [WIDTH-1:0]       s1_dp1;
    logic [WIDTH-1:0]       s1_dp2;
    logic [7:0]             s1_chn;

    assign c      = din_chn[CW-1:0];
    // Any tag bit above the channel index field marks the sample as out of range.
    assign chn_ok = (din_chn >> CW) == 8'd0;
    assign acc    = din_dv & chn_ok;
    // During sync, every channel is forced to even phase, so the sample in
    // that same cycle is always treated as the first half of a pair.
    assign odd     = acc & ph[c] & ~sync_in;
    assign even_wr = acc & (sync_in | ~ph[c]);

    // Hold storage has no reset. The phase bits decide whether an entry is valid.
    always_ff @(posedge clk) begin
        if (even_wr)
            hold[c] <= din_dq;
    end

    always_ff @(posedge clk) begin
        if (odd) begin
            s1_dp1 <= hold[c];
            s1_dp2 <= din_dq;
            s1_chn <= din_chn;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph        <= '0;
            vld_pipe  <= '0;
            sync_pipe <= '0;
            dout_dp1  <= '0;
            dout_dp2  <= '0;
            dout_chn  <= '0;
        end else begin
            if (sync_in) begin
                ph <= '0;
                if (acc)
                    ph[c] <= 1'b1;   // later assignment wins over the clear
            end else if (acc) begin
                ph[c] <= ~ph[c];
            end

            vld_pipe  <= {vld_pipe[0], odd};
            sync_pipe <= {sync_pipe[0], sync_in};

            if (vld_pipe[0]) begin
                dout_dp1 <= s1_dp1;
                dout_dp2 <= s1_dp2;
                dout_chn <= s1_chn;
            end
        end
    end

    assign dout_dv  = vld_pipe[1];
    assign sync_out = sync_pipe[1];

`ifdef PRACH_HB1_DMUX_CHK_EN
    logic [CW-1:0] exp_chn;
    logic [CW-1:0] base;
    logic          bad;
    logic          err_q;

    // On sync, the sample in the same cycle is checked against channel 0.
    assign base = sync_in ? '0 : exp_chn;
    assign bad  = din_dv & (~chn_ok | (c != base));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exp_chn <= '0;
            err_q   <= 1'b0;
        end else begin
            // Whether or not the tag matched, the next expected channel is tag+1.
            if (din_dv)
                exp_chn <= c + 1'b1;
            else if (sync_in)
                exp_chn <= '0;
            err_q <= (err_q & ~sync_in) | bad;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prach_hb1_dmux.sv
module tb_prach_hb1_dmux;

    localparam int NCH = 16;
    localparam int W   = 16;
`ifdef PRACH_HB1_DMUX_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din_dq;
    logic         din_dv;
    logic [7:0]   din_chn;
    logic         sync_in;
    logic [W-1:0] dout_dp1;
    logic [W-1:0] dout_dp2;
    logic         dout_dv;
    logic [7:0]   dout_chn;
    logic         sync_out;
    logic         err;

    prach_hb1_dmux #(.NUM_CHANNEL(NCH), .WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .din_dq(din_dq), .din_dv(din_dv), .din_chn(din_chn), .sync_in(sync_in),
        .dout_dp1(dout_dp1), .dout_dp2(dout_dp2), .dout_dv(dout_dv),
        .dout_chn(dout_chn), .sync_out(sync_out), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          dv;
        bit          sync;
        logic [7:0]  chn;
        logic [15:0] dq;
        bit          ep;     // this vector completes a pair
        logic [15:0] e1;
        logic [15:0] e2;
        bit          eerr;   // err expected after this vector's edge
    } vec_t;

    typedef struct {
        logic [15:0] dp1;
        logic [15:0] dp2;
        logic [7:0]  chn;
        int          due;
    } pair_t;

    vec_t        vecs[$];
    pair_t       sb[$];
    pair_t       pm;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          mon_en = 1'b0;
    logic [15:0] last1 = '0;
    logic [15:0] last2 = '0;
    logic [7:0]  lastc = '0;
    bit          sync_drv [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void addv(bit dv, bit sync, int chn, int dq, bit ep, int e1, int e2, bit eerr);
        vec_t v;
        v.dv = dv; v.sync = sync; v.chn = 8'(chn); v.dq = 16'(dq);
        v.ep = ep; v.e1 = 16'(e1); v.e2 = 16'(e2); v.eerr = eerr;
        vecs.push_back(v);
    endfunction

    task automatic drive(input bit dv, input bit sync, input logic [7:0] chn, input logic [15:0] dq);
        din_dv  = dv;
        sync_in = sync;
        din_chn = chn;
        din_dq  = dq;
        sync_drv[cyc] = sync;
    endtask

    task automatic push_pair(input logic [15:0] e1, input logic [15:0] e2, input logic [7:0] ch);
        pair_t p;
        p.dp1 = e1; p.dp2 = e2; p.chn = ch; p.due = cyc + 2;
        sb.push_back(p);
    endtask

    // Output monitor: pairs come from the scoreboard, held values and sync_out
    // are checked on every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                total++; bad++;
                $display("FAIL pair_missing: got none want dp1=%0d dp2=%0d chn=%0d due %0d", sb[0].dp1, sb[0].dp2, sb[0].chn, sb[0].due);
                void'(sb.pop_front());
            end
            if (dout_dv) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pair_spurious: got dp1=%0d dp2=%0d chn=%0d want no pulse (cyc %0d)", dout_dp1, dout_dp2, dout_chn, cyc);
                end else begin
                    pm = sb.pop_front();
                    chk("pair_dp1", 32'(dout_dp1), 32'(pm.dp1));
                    chk("pair_dp2", 32'(dout_dp2), 32'(pm.dp2));
                    chk("pair_chn", 32'(dout_chn), 32'(pm.chn));
                    chk("pair_cycle", 32'(cyc), 32'(pm.due));
                    last1 = pm.dp1; last2 = pm.dp2; lastc = pm.chn;
                end
            end else begin
                chk("hold_dp1", 32'(dout_dp1), 32'(last1));
                chk("hold_dp2", 32'(dout_dp2), 32'(last2));
                chk("hold_chn", 32'(dout_chn), 32'(lastc));
            end
            if (cyc >= 2)
                chk("sync_out", 32'(sync_out), 32'(sync_drv[cyc-2]));
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) sync_drv[i] = 1'b0;

        // Back-to-back: channels 0..15 twice, so the second pass completes each pair.
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 16; c++)
                addv(1, 0, c, 100*c + k, k == 1, 100*c, 100*c + 1, 0);
        // Gapped: one valid sample every third cycle, with junk on the idle cycles.
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 16; c++) begin
                addv(0, 0, (c*37 + 200) & 255, 16'hdead, 0, 0, 0, 0);
                addv(0, 0, (c*11 + 17) & 255, 16'hbeef, 0, 0, 0, 0);
                addv(1, 0, c, 100*c + k, k == 1, 100*c, 100*c + 1, 0);
            end
        // Store only the even halves, then sync with channel 0 sample 7.
        for (int c = 0; c < 16; c++)
            addv(1, 0, c, 1000 + c, 0, 0, 0, 0);
        addv(1, 1, 0, 7, 0, 0, 0, 0);
        addv(1, 0, 0, 9, 1, 7, 9, CHK);
        addv(0, 1, 0, 0, 0, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0);
        // Sequence error 0,1,3, then sync; then an out-of-range tag 20,
        // followed by channel 4 pairing with no stray sample.
        addv(1, 0, 0, 1, 0, 0, 0, 0);
        addv(1, 0, 1, 2, 0, 0, 0, 0);
        addv(1, 0, 3, 3, 0, 0, 0, CHK);
        addv(0, 0, 0, 0, 0, 0, 0, CHK);
        addv(0, 0, 0, 0, 0, 0, 0, CHK);
        addv(0, 1, 0, 0, 0, 0, 0, 0);
        addv(1, 0, 20, 5, 0, 0, 0, CHK);
        addv(0, 0, 0, 0, 0, 0, 0, CHK);
        addv(1, 0, 4, 50, 0, 0, 0, CHK);
        addv(1, 0, 4, 51, 1, 50, 51, CHK);
        addv(0, 1, 0, 0, 0, 0, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 8'd0, 16'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dv",   32'(dout_dv),  0);
        chk("rst_dp1",  32'(dout_dp1), 0);
        chk("rst_dp2",  32'(dout_dp2), 0);
        chk("rst_chn",  32'(dout_chn), 0);
        chk("rst_sync", 32'(sync_out), 0);
        chk("rst_err",  32'(err),      0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].dv, vecs[i].sync, vecs[i].chn, vecs[i].dq);
            if (vecs[i].ep) push_pair(vecs[i].e1, vecs[i].e2, vecs[i].chn);
            @(posedge clk); #1;
            chk("err", 32'(err), 32'(vecs[i].eerr));
        end

        // Reset mid-pair: the even sample 42 must never come out.
        drive(1, 0, 8'd3, 16'd42);
        @(posedge clk); #1;
        chk("err_pre_rst", 32'(err), 32'(CHK));
        drive(0, 0, 8'd0, 16'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        last1 = '0; last2 = '0; lastc = '0;
        chk("mid_rst_dv",   32'(dout_dv),  0);
        chk("mid_rst_dp1",  32'(dout_dp1), 0);
        chk("mid_rst_dp2",  32'(dout_dp2), 0);
        chk("mid_rst_chn",  32'(dout_chn), 0);
        chk("mid_rst_sync", 32'(sync_out), 0);
        chk("mid_rst_err",  32'(err),      0);
        rst_n = 1'b1;
        drive(1, 0, 8'd3, 16'd10);
        @(posedge clk); #1;
        chk("err_post_rst", 32'(err), 32'(CHK));
        drive(1, 0, 8'd3, 16'd11);
        push_pair(16'd10, 16'd11, 8'd3);
        @(posedge clk); #1;
        drive(0, 0, 8'd0, 16'd0);

        repeat (5) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending pairs want 0", sb.size());
        end
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
